// File: rtl/vpu_deload_ctrl_if.sv
// Handshake/bus bundle between the deload sequencer and its environment
// (job control, output-buffer write port and vpu_deload mirror outputs).
interface vpu_deload_ctrl_if #(
  parameter int CNT_W  = 3,
  parameter int TILE_W = 2,
  parameter int ADDR_W = 8
);
  logic              start;
  logic              compute_done;
  logic              wr_ready;
  logic              deload;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  row_idx;
  logic [CNT_W-1:0]  col_idx;
  logic [TILE_W-1:0] tile_idx;
  logic              busy;
  logic              tile_done;
  logic              all_done;

  modport master (
    output start, compute_done, wr_ready,
    input  deload, wr_valid, wr_addr, row_idx, col_idx, tile_idx,
    input  busy, tile_done, all_done
  );

  modport slave (
    input  start, compute_done, wr_ready,
    output deload, wr_valid, wr_addr, row_idx, col_idx, tile_idx,
    output busy, tile_done, all_done
  );
endinterface

// File: rtl/vpu_deload_ctrl.sv
// Tile-by-tile deload sequencer: waits for compute completion, drains the array
// pipeline, then streams ROW_A*ROW_A beats per tile under write back-pressure.
module vpu_deload_ctrl #(
  parameter int ROW_A     = 8,
  parameter int TILES     = 4,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = $clog2(ROW_A),
  parameter int TILE_W    = $clog2(TILES),
  parameter int ADDR_W    = $clog2(TILES * ROW_A * ROW_A)
) (
  input  logic              clk,
  input  logic              reset,
  vpu_deload_ctrl_if.slave  bus
);

  localparam int DRAIN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(ROW_A - 1);
  localparam logic [TILE_W-1:0]  LAST_TILE = TILE_W'(TILES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LD  = DRAIN_W'(DRAIN_CYC);
  localparam logic [ADDR_W-1:0]  TILE_SZ   = ADDR_W'(ROW_A * ROW_A);
  localparam logic [ADDR_W-1:0]  ROW_SZ    = ADDR_W'(ROW_A);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CMP = 3'd1,
    S_DRAIN    = 3'd2,
    S_DELOAD   = 3'd3,
    S_TILE_END = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_row;
  logic [CNT_W-1:0]    r_col;
  logic [CNT_W-1:0]    w_row_nxt;
  logic [CNT_W-1:0]    w_col_nxt;
  logic [TILE_W-1:0]   r_tile;
  logic [TILE_W-1:0]   w_tile_nxt;
  logic [DRAIN_W-1:0]  r_drain;
  logic [DRAIN_W-1:0]  w_drain_nxt;
  logic                w_wr_valid;
  logic                w_tile_end;
  logic [ADDR_W-1:0]   w_addr;

  // State, mirror counters and drain counter; counters only move on accepted beats
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_row   <= {CNT_W{1'b0}};
      r_col   <= {CNT_W{1'b0}};
      r_tile  <= {TILE_W{1'b0}};
      r_drain <= {DRAIN_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_tile  <= w_tile_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_tile_nxt  = r_tile;
    w_drain_nxt = r_drain;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_WAIT_CMP;
          w_tile_nxt  = {TILE_W{1'b0}};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_CMP: begin
        if (bus.compute_done) begin
          if (DRAIN_CYC == 0) begin
            w_state_nxt = S_DELOAD;
          end else begin
            w_state_nxt = S_DRAIN;
            w_drain_nxt = DRAIN_LD;
          end
        end else begin
          w_state_nxt = S_WAIT_CMP;
        end
      end
      S_DRAIN: begin
        // Counter was loaded with DRAIN_CYC, so leaving at 1 gives exactly DRAIN_CYC cycles here
        w_drain_nxt = r_drain - DRAIN_W'(1);
        if (r_drain <= DRAIN_W'(1)) begin
          w_state_nxt = S_DELOAD;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DELOAD: begin
        if (bus.wr_ready) begin
          if (r_col == LAST_IDX) begin
            w_col_nxt = {CNT_W{1'b0}};
            if (r_row == LAST_IDX) begin
              w_row_nxt   = {CNT_W{1'b0}};
              w_state_nxt = S_TILE_END;
            end else begin
              w_row_nxt = r_row + CNT_W'(1);
            end
          end else begin
            w_col_nxt = r_col + CNT_W'(1);
          end
        end else begin
          w_state_nxt = S_DELOAD;
        end
      end
      S_TILE_END: begin
        if (r_tile == LAST_TILE) begin
          w_tile_nxt  = {TILE_W{1'b0}};
          w_state_nxt = S_IDLE;
        end else begin
          w_tile_nxt  = r_tile + TILE_W'(1);
          w_state_nxt = S_WAIT_CMP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_wr_valid = (r_state == S_DELOAD) && !reset;
  assign w_tile_end = (r_state == S_TILE_END) && !reset;
  assign w_addr     = ADDR_W'(r_tile) * TILE_SZ + ADDR_W'(r_row) * ROW_SZ + ADDR_W'(r_col);

  // deload must fire in the same cycle as the accept so vpu_deload and the mirrors step together
  assign bus.wr_valid  = w_wr_valid;
  assign bus.deload    = w_wr_valid && bus.wr_ready;
  assign bus.busy      = (r_state != S_IDLE) && !reset;
  assign bus.tile_done = w_tile_end;
  assign bus.all_done  = w_tile_end && (r_tile == LAST_TILE);
  assign bus.wr_addr   = reset ? {ADDR_W{1'b0}} : w_addr;
  assign bus.row_idx   = reset ? {CNT_W{1'b0}}  : r_row;
  assign bus.col_idx   = reset ? {CNT_W{1'b0}}  : r_col;
  assign bus.tile_idx  = reset ? {TILE_W{1'b0}} : r_tile;

endmodule

// File: tb/tb_vpu_deload_ctrl.sv
// Scoreboard bench for vpu_deload_ctrl: stimulus pushes expected beats/tile
// completions, a negedge monitor pops and compares them against the DUT.
module tb_vpu_deload_ctrl;

  localparam int ROW_A  = 4;
  localparam int TILES  = 2;
  localparam int DRAIN  = 2;
  localparam int RR     = ROW_A * ROW_A;
  localparam int CNT_W  = $clog2(ROW_A);
  localparam int TILE_W = $clog2(TILES);
  localparam int ADDR_W = $clog2(TILES * RR);

  typedef struct {
    int tile;
    bit last;
  } done_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   mode = 0;
  int   exp_q[$];
  done_t done_q[$];

  vpu_deload_ctrl_if #(.CNT_W(CNT_W), .TILE_W(TILE_W), .ADDR_W(ADDR_W)) bus ();
  vpu_deload_ctrl_if #(.CNT_W(CNT_W), .TILE_W(TILE_W), .ADDR_W(ADDR_W)) bus0 ();

  vpu_deload_ctrl #(.ROW_A(ROW_A), .TILES(TILES), .DRAIN_CYC(DRAIN)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  vpu_deload_ctrl #(.ROW_A(ROW_A), .TILES(TILES), .DRAIN_CYC(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Advance one cycle, then drive wr_ready for the new cycle and let logic settle
  task automatic tick();
    @(posedge clk);
    #1;
    case (mode)
      0: bus.wr_ready = 1'b1;
      1: bus.wr_ready = ~bus.wr_ready;
      default: bus.wr_ready = ($urandom_range(0, 9) < 7);
    endcase
    #1;
  endtask

  // Monitor: every accepted beat / tile completion is checked against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_wr_valid", bus.wr_valid, 0);
      chk("rst_deload", bus.deload, 0);
      chk("rst_tile_done", bus.tile_done, 0);
      chk("rst_addr", bus.wr_addr, 0);
    end else begin
      chk("deload_eq_accept", bus.deload, bus.wr_valid & bus.wr_ready);
      chk("all_done_without_tile_done", bus.all_done & ~bus.tile_done, 0);
      if (bus.deload) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          int a;
          a = exp_q.pop_front();
          chk("wr_addr", bus.wr_addr, a);
          chk("row_idx", bus.row_idx, (a % RR) / ROW_A);
          chk("col_idx", bus.col_idx, a % ROW_A);
          chk("tile_idx", bus.tile_idx, a / RR);
        end
      end
      if (bus.tile_done) begin
        chk("tile_done_expected", done_q.size() > 0, 1);
        chk("beats_left_at_tile_done", exp_q.size(), 0);
        if (done_q.size() > 0) begin
          done_t d;
          d = done_q.pop_front();
          chk("done_tile_idx", bus.tile_idx, d.tile);
          chk("all_done", bus.all_done, d.last);
        end
      end
    end
  end

  // One tile: compute_done, drain, stream; optional ignored pulses or mid-tile reset
  task automatic run_tile(input int t, input bit inj_cd, input bit inj_start, input int rst_beat);
    int lat;
    int n_acc;
    int cyc;
    for (int k = 0; k < RR; k++) exp_q.push_back(t * RR + k);
    done_q.push_back('{tile: t, last: (t == TILES - 1)});
    bus.compute_done = 1'b1;
    tick();
    bus.compute_done = 1'b0;
    lat = 0;
    while (!bus.wr_valid && lat < 20) begin
      if (inj_cd && lat == 0) bus.compute_done = 1'b1;
      tick();
      bus.compute_done = 1'b0;
      lat++;
    end
    chk("drain_latency", lat, DRAIN);
    n_acc = 0;
    cyc = 0;
    while (!bus.tile_done && cyc < 200) begin
      if (bus.deload) n_acc++;
      if (rst_beat != 0 && n_acc == rst_beat) begin
        reset = 1'b1;
        exp_q.delete();
        done_q.delete();
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_deload", bus.deload, 0);
        chk("post_rst_row", bus.row_idx, 0);
        chk("post_rst_col", bus.col_idx, 0);
        chk("post_rst_tile", bus.tile_idx, 0);
        chk("post_rst_addr", bus.wr_addr, 0);
        chk("post_rst_tile_done", bus.tile_done, 0);
        for (int i = 0; i < 4; i++) tick();
        return;
      end
      if (inj_start && cyc == 3) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      cyc++;
    end
    chk("tile_done_seen", bus.tile_done, 1);
    chk("accepted_beats", n_acc, RR);
    chk("wrap_row", bus.row_idx, 0);
    chk("wrap_col", bus.col_idx, 0);
    chk("tile_end_wr_valid", bus.wr_valid, 0);
    tick();
    if (t == TILES - 1) begin
      chk("busy_after_job", bus.busy, 0);
    end else begin
      chk("busy_between_tiles", bus.busy, 1);
      chk("wait_cmp_wr_valid", bus.wr_valid, 0);
    end
  endtask

  task automatic do_job(input bit inj_cd, input bit inj_start);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    for (int t = 0; t < TILES; t++) run_tile(t, inj_cd, inj_start, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.compute_done = 1'b0;
    bus.wr_ready = 1'b0;
    bus0.start = 1'b0;
    bus0.compute_done = 1'b0;
    bus0.wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    tick();
    chk("reset_busy", bus.busy, 0);
    chk("reset_row", bus.row_idx, 0);
    chk("reset_col", bus.col_idx, 0);
    chk("reset_tile", bus.tile_idx, 0);

    mode = 0;
    do_job(1'b0, 1'b0);
    mode = 1;
    do_job(1'b0, 1'b0);

    bus.compute_done = 1'b1;
    tick();
    bus.compute_done = 1'b0;
    chk("idle_cd_ignored", bus.busy, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("holds_in_wait_cmp_busy", bus.busy, 1);
    chk("holds_in_wait_cmp_valid", bus.wr_valid, 0);
    for (int t = 0; t < TILES; t++) run_tile(t, 1'b1, 1'b1, 0);

    mode = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_tile(0, 1'b0, 1'b0, 6);
    do_job(1'b0, 1'b0);

    mode = 2;
    for (int j = 0; j < 4; j++) begin
      do_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    mode = 0;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus0.compute_done = 1'b1;
    tick();
    bus0.compute_done = 1'b0;
    chk("d0_valid_next_cycle", bus0.wr_valid, 1);
    for (int k = 0; k < RR; k++) begin
      chk("d0_deload", bus0.deload, 1);
      chk("d0_addr", bus0.wr_addr, k);
      tick();
    end
    chk("d0_tile_done", bus0.tile_done, 1);
    chk("d0_all_done", bus0.all_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
